// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants for the lane traffic counter
// Purpose: lane index map, default sizing, lane FSM state encodings and the
//          timer-width helper used by lane_counter_slice.
// Ports:   none (package)
package traffic_pkg;

   localparam int NUM_LANES     = 8;
   localparam int CNT_W         = 8;
   localparam int START_DELAY   = 2;
   localparam int DEPART_CYCLES = 3;

   // Slice index of each lane inside the packed laneCounts bus
   localparam int LANE_N2 = 0;
   localparam int LANE_N1 = 1;
   localparam int LANE_E2 = 2;
   localparam int LANE_E1 = 3;
   localparam int LANE_S2 = 4;
   localparam int LANE_S1 = 5;
   localparam int LANE_W2 = 6;
   localparam int LANE_W1 = 7;

   localparam logic [1:0] RED   = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] FLOW  = 2'd2;

   typedef logic [1:0] laneState_t;

   // Timer must hold max(startDelay, departCycles)-1; never narrower than 1 bit
   function automatic int timerWidth(input int startDelay, input int departCycles);
      int m;
      m = (startDelay > departCycles) ? startDelay : departCycles;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/lane_counter_slice.sv
// rtl/lane_counter_slice.sv - one lane: arrival edge detect, green FSM, saturating count
// Purpose: counts vehicles arriving on one loop sensor and discharges them at a
//          fixed rate while the lane light is green.
// Ports:   clk      in  system clock, rising edge
//          rst      in  synchronous reset, active low
//          sensor   in  loop-sensor level for this lane
//          green    in  this lane's green light
//          count    out registered vehicle count
//          overflow out sticky saturation flag (COUNT_OVERFLOW_EN builds only)
module lane_counter_slice #(
   parameter int CNT_W         = traffic_pkg::CNT_W,
   parameter int START_DELAY   = traffic_pkg::START_DELAY,
   parameter int DEPART_CYCLES = traffic_pkg::DEPART_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sensor,
   input  logic             green,
`ifdef COUNT_OVERFLOW_EN
   output logic             overflow,
`endif
   output logic [CNT_W-1:0] count
);
   import traffic_pkg::*;

   localparam int TMR_W = timerWidth(START_DELAY, DEPART_CYCLES);
   localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_DELAY - 1);
   localparam logic [TMR_W-1:0] DEPART_LOAD = TMR_W'(DEPART_CYCLES - 1);

   logic             sQ;
   logic             sQQ;
   laneState_t       state;
   logic [TMR_W-1:0] tmr;
   logic             arr;
   logic             dep;
   logic             isMax;

   assign arr   = sQ & ~sQQ;
   // A departure slot needs green on this very edge; a dropping light wins
   assign dep   = (state == FLOW) && green && (tmr == '0);
   assign isMax = (count == {CNT_W{1'b1}});

   always_ff @(posedge clk) begin
      if (!rst) begin
         sQ  <= 1'b0;
         sQQ <= 1'b0;
      end else begin
         sQ  <= sensor;
         sQQ <= sQ;
      end
   end

   // Any loss of green returns to RED and throws away timer progress
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RED;
         tmr   <= '0;
      end else begin
         case (state)
            RED: begin
               if (green) begin
                  state <= START;
                  tmr   <= START_LOAD;
               end else begin
                  tmr   <= '0;
               end
            end
            START: begin
               if (!green) begin
                  state <= RED;
                  tmr   <= '0;
               end else if (tmr == '0) begin
                  state <= FLOW;
                  tmr   <= DEPART_LOAD;
               end else begin
                  tmr   <= tmr - 1'b1;
               end
            end
            FLOW: begin
               if (!green) begin
                  state <= RED;
                  tmr   <= '0;
               end else if (tmr == '0) begin
                  tmr   <= DEPART_LOAD;
               end else begin
                  tmr   <= tmr - 1'b1;
               end
            end
            default: begin
               state <= RED;
               tmr   <= '0;
            end
         endcase
      end
   end

   // Coincident arrival and departure cancel, except an empty lane still
   // keeps the arriving vehicle because the departure slot had nothing to take
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else begin
         case ({arr, dep})
            2'b10: if (!isMax) count <= count + CNT_W'(1);
            2'b01: if (count != '0) count <= count - CNT_W'(1);
            2'b11: if (count == '0) count <= CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef COUNT_OVERFLOW_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (arr && !dep && isMax) begin
         overflow <= 1'b1;
      end
   end
`endif

endmodule

// File: rtl/lane_traffic_counter.sv
// rtl/lane_traffic_counter.sv - per-lane vehicle counters feeding the packed lane-count bus
// Purpose: replicates lane_counter_slice per lane and packs the counts.
//          Optional feature macro: COUNT_OVERFLOW_EN adds laneOverflow.
// Ports:   clk          in  system clock, rising edge
//          rst          in  synchronous reset, active low
//          sensor       in  loop-sensor levels, bit i = lane i
//          green        in  lane green lights, bit i governs slice i
//          laneCounts   out {w1,w2,s1,s2,e1,e2,n1,n2}, lane i = [CNT_W*i +: CNT_W]
//          laneOverflow out sticky saturation flags (COUNT_OVERFLOW_EN only)
module lane_traffic_counter #(
   parameter int NUM_LANES     = traffic_pkg::NUM_LANES,
   parameter int CNT_W         = traffic_pkg::CNT_W,
   parameter int START_DELAY   = traffic_pkg::START_DELAY,
   parameter int DEPART_CYCLES = traffic_pkg::DEPART_CYCLES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_LANES-1:0]       sensor,
   input  logic [NUM_LANES-1:0]       green,
`ifdef COUNT_OVERFLOW_EN
   output logic [NUM_LANES-1:0]       laneOverflow,
`endif
   output logic [NUM_LANES*CNT_W-1:0] laneCounts
);

   for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
      lane_counter_slice #(
         .CNT_W         (CNT_W),
         .START_DELAY   (START_DELAY),
         .DEPART_CYCLES (DEPART_CYCLES)
      ) uLane (
         .clk      (clk),
         .rst      (rst),
         .sensor   (sensor[i]),
         .green    (green[i]),
`ifdef COUNT_OVERFLOW_EN
         .overflow (laneOverflow[i]),
`endif
         .count    (laneCounts[CNT_W*i +: CNT_W])
      );
   end

endmodule

// File: tb/tb_lane_traffic_counter.sv
// tb/tb_lane_traffic_counter.sv - scoreboard bench for lane_traffic_counter
module tb_lane_traffic_counter;

   localparam int SD  = 2;
   localparam int DC  = 3;
   localparam int MAXC = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  sensor = 8'h00;
   logic [7:0]  green  = 8'h00;
   logic [63:0] laneCounts;
`ifdef COUNT_OVERFLOW_EN
   logic [7:0]  laneOverflow;
`endif

   int passCnt  = 0;
   int totalCnt = 0;

   lane_traffic_counter dut (
      .clk        (clk),
      .rst        (rst),
      .sensor     (sensor),
      .green      (green),
`ifdef COUNT_OVERFLOW_EN
      .laneOverflow (laneOverflow),
`endif
      .laneCounts (laneCounts)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] counts;
      logic [7:0]  ovf;
   } expect_t;

   expect_t expQ[$];
   bit      started = 0;

   // Reference model: vehicles as integers, arrivals as "sampled high after
   // a sampled low", departures from the length of the current green run.
   int          mCnt[8];
   int          runLen[8];
   logic [7:0]  lastSample;
   logic [7:0]  prevSample;
   logic [7:0]  mOvf;

   always @(posedge clk) begin
      expect_t e;
      bit arrive, depart;
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            mCnt[i]   = 0;
            runLen[i] = 0;
         end
         lastSample = '0;
         prevSample = '0;
         mOvf       = '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            arrive = lastSample[i] && !prevSample[i];
            runLen[i] = green[i] ? runLen[i] + 1 : 0;
            depart = green[i] && (runLen[i] >= SD + DC + 1) &&
                     (((runLen[i] - (SD + DC + 1)) % DC) == 0);
            if (arrive && !depart) begin
               if (mCnt[i] < MAXC) mCnt[i]++;
               else mOvf[i] = 1'b1;
            end else if (depart && !arrive) begin
               if (mCnt[i] > 0) mCnt[i]--;
            end else if (arrive && depart) begin
               if (mCnt[i] == 0) mCnt[i] = 1;
            end
         end
         prevSample = lastSample;
         lastSample = sensor;
      end
      for (int i = 0; i < 8; i++) e.counts[8*i +: 8] = mCnt[i][7:0];
      e.ovf = mOvf;
      expQ.push_back(e);
      started = 1;
   end

   always @(negedge clk) begin
      expect_t e;
      if (started) begin
         totalCnt++;
         if (expQ.size() == 0) begin
            $display("FAIL scoreboard_empty: no expected entry for DUT output %h", laneCounts);
         end else begin
            e = expQ.pop_front();
`ifdef COUNT_OVERFLOW_EN
            if (laneCounts === e.counts && laneOverflow === e.ovf) passCnt++;
            else $display("FAIL scoreboard: laneCounts=%h ovf=%h required %h ovf=%h at %0t",
                          laneCounts, laneOverflow, e.counts, e.ovf, $time);
`else
            if (laneCounts === e.counts) passCnt++;
            else $display("FAIL scoreboard: laneCounts=%h required %h at %0t",
                          laneCounts, e.counts, $time);
`endif
         end
      end
   end

   task automatic cyc(input logic [7:0] s, input logic [7:0] g, input logic r);
      sensor = s;
      green  = g;
      rst    = r;
      @(posedge clk);
      #1;
   endtask

   task automatic spot(input string name, input int lane, input logic [7:0] want);
      logic [7:0] got;
      got = laneCounts[8*lane +: 8];
      totalCnt++;
      if (got === want) passCnt++;
      else $display("FAIL %s: lane %0d count=%0d required %0d", name, lane, got, want);
   endtask

   task automatic pulse(input int lane, input int n);
      logic [7:0] b;
      b = 8'h01 << lane;
      for (int k = 0; k < n; k++) begin
         cyc(b, 8'h00, 1'b1);
         cyc(8'h00, 8'h00, 1'b1);
      end
   endtask

   initial begin
      logic [7:0] gState;
      logic [7:0] sRand;

      // 1: reset with everything asserted
      cyc(8'hFF, 8'hFF, 1'b0);
      cyc(8'hFF, 8'hFF, 1'b0);
      totalCnt++;
      if (laneCounts === 64'h0) passCnt++;
      else $display("FAIL reset_counts: laneCounts=%h required 0", laneCounts);

      // 2: single pulse then a long hold on n1
      cyc(8'h00, 8'h00, 1'b1);
      cyc(8'h00, 8'h00, 1'b1);
      cyc(8'h02, 8'h00, 1'b1);
      spot("arrival_latency_early", 1, 8'd0);
      cyc(8'h00, 8'h00, 1'b1);
      spot("arrival_latency", 1, 8'd1);
      for (int k = 0; k < 10; k++) cyc(8'h02, 8'h00, 1'b1);
      cyc(8'h00, 8'h00, 1'b1);
      cyc(8'h00, 8'h00, 1'b1);
      spot("held_sensor_once", 1, 8'd2);

      // 3: discharge timing on n1 from 5
      pulse(1, 3);
      spot("preload_5", 1, 8'd5);
      for (int k = 0; k < 5; k++) cyc(8'h00, 8'h02, 1'b1);
      spot("start_lost_time", 1, 8'd5);
      cyc(8'h00, 8'h02, 1'b1);
      spot("first_departure", 1, 8'd4);
      for (int k = 0; k < 3; k++) cyc(8'h00, 8'h02, 1'b1);
      spot("second_departure", 1, 8'd3);
      for (int k = 0; k < 3; k++) cyc(8'h00, 8'h02, 1'b1);
      spot("third_departure", 1, 8'd2);
      for (int k = 0; k < 6; k++) cyc(8'h00, 8'h00, 1'b1);
      spot("green_dropped", 1, 8'd2);

      // 4: coincident arrival and departure on an empty lane (n2) and on 7 (e2)
      for (int k = 0; k < 6; k++) cyc((k == 4) ? 8'h01 : 8'h00, 8'h01, 1'b1);
      spot("coincident_empty", 0, 8'd1);
      cyc(8'h00, 8'h00, 1'b1);
      pulse(2, 7);
      for (int k = 0; k < 6; k++) cyc((k == 4) ? 8'h04 : 8'h00, 8'h04, 1'b1);
      spot("coincident_nonempty", 2, 8'd7);
      cyc(8'h00, 8'h00, 1'b1);

      // 5: saturation on w1
      pulse(7, 256);
      spot("saturate_w1", 7, 8'hFF);
`ifdef COUNT_OVERFLOW_EN
      totalCnt++;
      if (laneOverflow[7] === 1'b1) passCnt++;
      else $display("FAIL overflow_flag: laneOverflow[7]=%b required 1", laneOverflow[7]);
`endif

      // 6: reset mid-FLOW on e1 with 9 queued, then a full restart
      pulse(3, 9);
      spot("preload_9", 3, 8'd9);
      for (int k = 0; k < 4; k++) cyc(8'h00, 8'h08, 1'b1);
      cyc(8'h00, 8'h08, 1'b0);
      spot("reset_mid_flow", 3, 8'd0);
      spot("reset_clears_w1", 7, 8'd0);
      cyc(8'h08, 8'h08, 1'b1);
      for (int k = 0; k < 4; k++) cyc(8'h00, 8'h08, 1'b1);
      spot("restart_no_early_departure", 3, 8'd1);
      cyc(8'h00, 8'h08, 1'b1);
      spot("restart_first_departure", 3, 8'd0);
      cyc(8'h00, 8'h00, 1'b1);

      // Randomised traffic: long green runs, sparse sensors, rare resets
      gState = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(19, 0) == 0) gState[i] = ~gState[i];
            sRand[i] = ($urandom_range(2, 0) == 0);
         end
         cyc(sRand, gState, ($urandom_range(249, 0) != 0));
      end
      // Heavy arrivals with no green to push lanes toward saturation
      for (int n = 0; n < 1200; n++) begin
         cyc($urandom_range(255, 0), 8'h00, 1'b1);
         cyc(8'h00, 8'h00, 1'b1);
      end

      cyc(8'h00, 8'h00, 1'b1);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
